// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8N1 echo UART.
// State encodings are fixed so waveforms read the same across tools.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ_HZ = 100_000_000;
  localparam int DEFAULT_BAUD_RATE   = 115200;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter. A start request in IDLE latches one byte and
// sends a full frame; requests while busy are ignored.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       data_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        out_d  = 1'b1;
        busy_d = 1'b0;
        if (start && !busy_q) begin
          shift_d = data;
          cnt_d   = '0;
          out_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          out_d   = shift_q[0];
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          // shift right so the next bit to send is always at position 0/1
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            out_d   = 1'b1;
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            out_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out = out_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: rtl/uart.sv
// 8N1 UART with echo loopback: every well-framed byte received on
// data_in_rx is retransmitted on data_out by the uart_tx instance.
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD_RATE   = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       data_in_rx,
  output logic       data_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       rx_open,
  output logic       rx_valid,
  output logic [7:0] rx_saved
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             sync1_q, sync2_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_saved_q, rx_saved_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_line;

  // Two-flop synchronizer; reset high so an idle line is not a start bit.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= data_in_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_line = sync2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_saved_d = rx_saved_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_line) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_bit_q] = rx_line;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_line ? RX_CLEANUP : RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_CLEANUP: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_saved_d = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_saved_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_saved_q <= rx_saved_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Open only while idle on a high line, so it falls together with START entry.
  assign rx_open  = (rx_state_q == RX_IDLE) && rx_line;
  assign rx_valid = rx_valid_q;
  assign rx_saved = rx_saved_q;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .areset  (areset),
    .start   (rx_valid_q),
    .data    (rx_saved_q),
    .data_out(data_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_uart.sv
// Echo UART bench: drives serial frames, decodes the echoed line with a
// behavioural receiver and compares against an expected-byte model.
module tb_uart;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HB     = CPB / 2;

  logic       clk = 1'b0;
  logic       areset;
  logic       data_in_rx;
  logic       data_out;
  logic       tx_busy;
  logic       tx_done;
  logic       rx_open;
  logic       rx_valid;
  logic [7:0] rx_saved;

  int compared   = 0;
  int mismatched = 0;

  int rx_valid_cnt = 0;
  int tx_done_cnt  = 0;
  int double_rx    = 0;
  int double_done  = 0;
  int busy_run     = 0;
  int bad_stop     = 0;
  logic prev_rv    = 1'b0;
  logic prev_td    = 1'b0;
  byte unsigned tx_frames[$];
  int           busy_lens[$];

  uart #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .data_in_rx(data_in_rx),
    .data_out  (data_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .rx_open   (rx_open),
    .rx_valid  (rx_valid),
    .rx_saved  (rx_saved)
  );

  always #5 clk = ~clk;

  // Pulse counters and busy-length recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (areset) begin
      prev_rv  <= 1'b0;
      prev_td  <= 1'b0;
      busy_run <= 0;
    end else begin
      if (rx_valid) rx_valid_cnt <= rx_valid_cnt + 1;
      if (tx_done)  tx_done_cnt  <= tx_done_cnt + 1;
      if (rx_valid && prev_rv) double_rx   <= double_rx + 1;
      if (tx_done && prev_td)  double_done <= double_done + 1;
      prev_rv <= rx_valid;
      prev_td <= tx_done;
      if (tx_busy) begin
        busy_run <= busy_run + 1;
      end else if (busy_run != 0) begin
        busy_lens.push_back(busy_run);
        busy_run <= 0;
      end
    end
  end

  // Reference serial receiver on data_out: centre-sampled 8N1 decode.
  initial begin : tx_decoder
    byte unsigned b;
    forever begin
      @(negedge data_out);
      repeat (HB) @(negedge clk);
      if (data_out === 1'b0) begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = data_out;
        end
        repeat (CPB) @(negedge clk);
        if (data_out !== 1'b1) bad_stop++;
        tx_frames.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    data_in_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) chk("rx_open_mid_frame", rx_open, 1'b0);
      data_in_rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    data_in_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    data_in_rx = 1'b1;
  endtask

  logic [7:0] good_bytes[6];
  logic [7:0] model_saved;
  int         exp_frames;
  bit         found;
  int         lat;

  initial begin
    areset     = 1'b1;
    data_in_rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_data_out", data_out, 1'b1);
    chk("reset_tx_busy",  tx_busy,  1'b0);
    chk("reset_tx_done",  tx_done,  1'b0);
    chk("reset_rx_open",  rx_open,  1'b1);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_saved", rx_saved, 8'h00);
    areset = 1'b0;
    repeat (5) @(negedge clk);

    model_saved = 8'h00;
    exp_frames  = 0;
    good_bytes[0] = 8'h5A;
    for (int i = 1; i < 5; i++) good_bytes[i] = 8'($urandom_range(0, 255));
    good_bytes[5] = 8'h5A;

    // Good frames, each echoed exactly once.
    for (int n = 0; n < 6; n++) begin
      send_byte(good_bytes[n], 1'b1);
      model_saved = good_bytes[n];
      exp_frames++;
      found = 1'b0;
      lat   = 0;
      for (int k = 0; k < 10; k++) begin
        if (rx_valid === 1'b1) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
        lat++;
      end
      chk("rx_valid_seen", found, 1'b1);
      chk("rx_valid_latency_ok", (lat <= 5), 1'b1);
      chk("rx_saved", rx_saved, model_saved);
      @(negedge clk);
      chk("rx_valid_single", rx_valid, 1'b0);
      chk("echo_start_bit", data_out, 1'b0);
      chk("echo_busy", tx_busy, 1'b1);
      repeat (CPB * 10 + 20) @(negedge clk);
      chk("rx_open_after", rx_open, 1'b1);
      chk("tx_idle_after", tx_busy, 1'b0);
      chk("rx_valid_count", rx_valid_cnt, exp_frames);
      chk("tx_done_count", tx_done_cnt, exp_frames);
      chk("tx_frame_count", tx_frames.size(), exp_frames);
      if (tx_frames.size() > 0) chk("echo_byte", tx_frames[$], model_saved);
      if (busy_lens.size() > 0) chk("busy_length", busy_lens[$], 10 * CPB);
      chk("pulse_widths", double_rx + double_done, 0);
      chk("echo_stop_bits", bad_stop, 0);
      $display("byte %0d: sent %02h rx_saved %02h echo frames %0d", n, good_bytes[n], rx_saved, tx_frames.size());
    end

    // Framing error: nothing reported, nothing echoed.
    send_byte(8'hA5, 1'b0);
    repeat (CPB * 12) @(negedge clk);
    chk("ferr_rx_valid_count", rx_valid_cnt, exp_frames);
    chk("ferr_rx_saved", rx_saved, model_saved);
    chk("ferr_tx_frames", tx_frames.size(), exp_frames);
    chk("ferr_busy_frames", busy_lens.size(), exp_frames);
    chk("ferr_rx_open", rx_open, 1'b1);
    $display("framing error frame a5: rx_saved %02h echo frames %0d", rx_saved, tx_frames.size());

    // Short low glitch shorter than half a bit.
    data_in_rx = 1'b0;
    repeat (HB / 2) @(negedge clk);
    data_in_rx = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    chk("glitch_rx_valid_count", rx_valid_cnt, exp_frames);
    chk("glitch_rx_saved", rx_saved, model_saved);
    chk("glitch_tx_frames", tx_frames.size(), exp_frames);
    chk("glitch_tx_busy", tx_busy, 1'b0);
    $display("glitch: rx_valid count %0d", rx_valid_cnt);

    // Reset in the middle of an echo start bit.
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tx_busy === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("pre_reset_busy_seen", found, 1'b1);
    repeat (HB - 2) @(negedge clk);
    chk("pre_reset_data_out", data_out, 1'b0);
    #2 areset = 1'b1;
    #1;
    chk("async_reset_data_out", data_out, 1'b1);
    chk("async_reset_tx_busy", tx_busy, 1'b0);
    chk("async_reset_rx_valid", rx_valid, 1'b0);
    chk("async_reset_rx_saved", rx_saved, 8'h00);
    $display("reset mid-frame: data_out %0b tx_busy %0b", data_out, tx_busy);
    @(negedge clk);
    areset = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- 8N1 UART with internal echo loopback: a serial receiver and a serial transmitter sharing one clock domain.
- Every byte received on data_in_rx is automatically retransmitted on data_out.
- Sits at the board serial pin boundary.
- Received byte and status flags are exported for observation.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency
BAUD_RATE, 115200, serial bit rate
CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (=868), derived localparam; clocks per bit period
HALF_BIT, CLKS_PER_BIT/2 (=434), derived localparam

Ports:
clk  input  1  system clock, rising edge
areset  input  1  asynchronous active-high reset
data_in_rx  input  1  serial RX line, idle high, asynchronous to clk
data_out  output  1  serial TX line, idle high
tx_busy  output  1  high while a TX frame (start, data, stop) is on the line
tx_done  output  1  one-cycle pulse when a TX stop bit completes
rx_open  output  1  high while the receiver is idle and ready for a start bit
rx_valid  output  1  one-cycle pulse when a complete, well-framed byte is received
rx_saved  output  8  last good received byte; held until the next good byte

Behaviour:
- Reset values (async, areset=1):
  - data_out=1, tx_busy=0, tx_done=0
  - rx_open=1, rx_valid=0, rx_saved=8'h00
  - both FSMs in IDLE; counters cleared; synchronizer flops set to 1
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- RX input: data_in_rx passes through a 2-flop synchronizer before any use.
- RX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE
  - IDLE: rx_open=1. Synchronized line low moves to START; rx_open drops in the same cycle.
  - START: wait HALF_BIT. If the line is still low, go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT, sample one bit into shift register position 0..7 (LSB first). After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT, sample at stop-bit centre.
    - 1: go to CLEANUP.
    - 0: framing error. Return to IDLE with no rx_valid and rx_saved unchanged.
  - CLEANUP: wait HALF_BIT (end of stop bit). Then load rx_saved, pulse rx_valid for exactly one cycle, and return to IDLE.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE
  - Start condition: in IDLE, rx_valid==1 and tx_busy==0. Latch rx_saved into the TX shift register and set tx_busy=1.
  - START: drive 0 for CLKS_PER_BIT.
  - DATA: drive bits 0..7, each for CLKS_PER_BIT.
  - STOP: drive 1 for CLKS_PER_BIT. Then tx_busy=0, tx_done=1 for one cycle, return to IDLE.
  - rx_valid arriving while tx_busy=1 is dropped (no queueing).
  - Start decision is level-sampled per cycle, so a one-cycle rx_valid in IDLE always starts exactly one frame.
- Latency: echo start bit begins 1 cycle after the rx_valid pulse. A full echo frame lasts 10*CLKS_PER_BIT cycles.
- Simultaneous events: RX and TX are independent. A new byte can be received while TX is busy. Its rx_valid is ignored by TX if TX is still busy.
- Reset mid-frame: aborts both FSMs immediately; data_out returns to 1 asynchronously.
- Synchronous registers only, apart from the async reset.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, CLEANUP)
  - tx_state_t enum (IDLE, START, DATA, STOP)
  - default CLK_FREQ_HZ and BAUD_RATE constants
- One natural sub-module: uart_tx, with ports clk, areset, start, data[7:0], data_out, tx_busy, tx_done.
- The receiver, synchronizer and loopback glue stay in uart.

Test Plan:
1. Reset: hold areset 20 ns -> data_out=1, tx_busy=0, tx_done=0, rx_open=1, rx_valid=0, rx_saved=0.
2. RX 0x5A at 8680 ns/bit -> rx_valid single-cycle pulse within ~5 cycles after the stop bit ends; rx_saved=8'h5A; rx_open low during the frame and high after.
3. Loopback: after item 2, sample data_out at bit centres starting 1.5 bit periods after its falling edge -> 8'h5A. tx_busy high ~86800 ns, then a single tx_done pulse.
4. Forced retrigger: once tx_busy==0, drive internal rx_valid=1 for one cycle with rx_saved=8'h5A -> exactly one more 0x5A frame on data_out.
5. Framing error: send 0xA5 with stop bit 0 -> no rx_valid, rx_saved keeps its prior value, no TX frame.
6. Glitch and reset: a 2000 ns low pulse on data_in_rx -> no reception. Assert areset mid-TX frame -> data_out=1 and tx_busy=0 immediately.
